// File: rtl/fc_dense_if.sv
// Bus bundle of the dense stage: start/busy/done handshake, layer-memory read port,
// weight/bias ROM port and the per-neuron score output.
interface fc_dense_if #(
    parameter int N_OUT = 4
);
    localparam int OIDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic              start;
    logic              busy;
    logic              done;
    logic              crd;
    logic [11:0]       caddr_rd;
    logic [19:0]       cdata_rd;
    logic [2:0]        csel;
    logic [12:0]       waddr;
    logic [19:0]       wdata;
    logic [19:0]       bdata;
    logic [OIDX_W-1:0] oidx;
    logic              ovalid;
    logic [19:0]       odata;

    // master is the surrounding system (memories, ROMs, sequencer); slave is the dense stage
    modport master (
        output start, cdata_rd, wdata, bdata,
        input  busy, done, crd, caddr_rd, csel, waddr, oidx, ovalid, odata
    );

    modport slave (
        input  start, cdata_rd, wdata, bdata,
        output busy, done, crd, caddr_rd, csel, waddr, oidx, ovalid, odata
    );
endinterface

// File: rtl/fc_dense.sv
// Dense stage: streams the flattened map once per neuron, multiply-accumulates against the
// weight ROM, adds the bias and emits one rounded, saturated Q4.16 score per neuron.
module fc_dense #(
    parameter int N_IN  = 2048,
    parameter int N_OUT = 4,
    parameter bit RELU  = 1'b0
) (
    input logic       clk,
    input logic       reset,
    fc_dense_if.slave bus
);
    localparam int OIDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic signed [36:0] SAT_MAX = 37'sd524287;
    localparam logic signed [36:0] SAT_MIN = -37'sd524288;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_WAIT, S_OUT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic signed [51:0] acc_q, acc_d;
    logic [11:0]        caddr_q, caddr_d;
    logic [12:0]        waddr_q, waddr_d;
    logic [OIDX_W-1:0]  oidx_q, oidx_d;
    logic               crd_q, crd_d;
    logic               dvalid_q, dvalid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovalid_q, ovalid_d;
    logic [19:0]        odata_q, odata_d;

    logic signed [39:0] prod;
    logic signed [51:0] prod_ext;
    logic signed [51:0] bias_ext;

    assign prod     = $signed(bus.cdata_rd) * $signed(bus.wdata);
    assign prod_ext = {{12{prod[39]}}, prod};
    assign bias_ext = {{16{bus.bdata[19]}}, bus.bdata, 16'd0};

    // Round half-up from Q.32 to Q.16, saturate to 20 bits, then optionally clamp negatives.
    function automatic logic [19:0] score(input logic signed [51:0] a);
        logic signed [36:0] r;
        logic [19:0]        res;
        r = $signed({a[51], a[51:16]}) + $signed({36'd0, a[15]});
        if (r > SAT_MAX)
            res = 20'h7FFFF;
        else if (r < SAT_MIN)
            res = 20'h80000;
        else
            res = r[19:0];
        if (RELU && res[19])
            res = 20'h00000;
        return res;
    endfunction

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        caddr_d  = caddr_q;
        oidx_d   = oidx_q;
        crd_d    = crd_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovalid_d = 1'b0;
        odata_d  = odata_q;
        dvalid_d = crd_q;

        if (dvalid_q)
            acc_d = acc_q + prod_ext;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    crd_d   = 1'b1;
                    caddr_d = 12'd0;
                    oidx_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                // bdata follows oidx, so the bias is loaded in the first read cycle,
                // which is also the only RUN cycle with no read data returning.
                if (!dvalid_q)
                    acc_d = bias_ext;
                if (caddr_q == 12'(N_IN - 1)) begin
                    state_d = S_WAIT;
                    crd_d   = 1'b0;
                    caddr_d = 12'd0;
                end else begin
                    caddr_d = caddr_q + 12'd1;
                end
            end
            S_WAIT: begin
                state_d  = S_OUT;
                ovalid_d = 1'b1;
                odata_d  = score(acc_d);
            end
            S_OUT: begin
                if (oidx_q == OIDX_W'(N_OUT - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_RUN;
                    crd_d   = 1'b1;
                    caddr_d = 12'd0;
                    oidx_d  = oidx_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        waddr_d = 13'(oidx_d) * 13'(N_IN) + 13'(caddr_d);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            caddr_q  <= '0;
            waddr_q  <= '0;
            oidx_q   <= '0;
            crd_q    <= 1'b0;
            dvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            caddr_q  <= caddr_d;
            waddr_q  <= waddr_d;
            oidx_q   <= oidx_d;
            crd_q    <= crd_d;
            dvalid_q <= dvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.crd      = crd_q;
    assign bus.caddr_rd = caddr_q;
    assign bus.csel     = crd_q ? 3'b101 : 3'b000;
    assign bus.waddr    = waddr_q;
    assign bus.oidx     = oidx_q;
    assign bus.ovalid   = ovalid_q;
    assign bus.odata    = odata_q;
endmodule

// File: tb/tb_fc_dense.sv
// Bench for fc_dense: a RELU-off and a RELU-on instance run the same directed vectors against a
// memory/ROM model that answers one cycle late; scores, strobe timing and read-port activity are checked.
module tb_fc_dense;
    localparam int N_IN      = 2048;
    localparam int N_OUT     = 4;
    localparam int RUN_BOUND = 9000;
    localparam int DONE_AT   = (N_IN + 2) * N_OUT + 1;

    typedef struct {
        logic [19:0]      x0, xr, w0, wr;
        logic [3:0][19:0] bias, exp0, exp1;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    int               cyc = 0;
    int               n_checks = 0;
    int               n_pass = 0;
    logic [19:0]      cur_x0, cur_xr, cur_w0, cur_wr;
    logic [3:0][19:0] cur_bias = '0;
    vec_t             vecs[6];

    fc_dense_if #(.N_OUT(N_OUT)) bus0();
    fc_dense_if #(.N_OUT(N_OUT)) bus1();

    fc_dense #(.N_IN(N_IN), .N_OUT(N_OUT), .RELU(1'b0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
    fc_dense #(.N_IN(N_IN), .N_OUT(N_OUT), .RELU(1'b1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Input element 0 and weight 0 of every neuron can differ from the rest of the map.
    always @(posedge clk) begin
        bus0.cdata_rd <= (bus0.caddr_rd == 12'd0) ? cur_x0 : cur_xr;
        bus0.wdata    <= (bus0.waddr[10:0] == 11'd0) ? cur_w0 : cur_wr;
        bus1.cdata_rd <= (bus1.caddr_rd == 12'd0) ? cur_x0 : cur_xr;
        bus1.wdata    <= (bus1.waddr[10:0] == 11'd0) ? cur_w0 : cur_wr;
    end

    assign bus0.bdata = cur_bias[bus0.oidx];
    assign bus1.bdata = cur_bias[bus1.oidx];

    function automatic vec_t mkVec(input logic [19:0] x0, xr, w0, wr, e0, e1);
        vec_t v;
        v.x0 = x0; v.xr = xr; v.w0 = w0; v.wr = wr;
        v.bias = '0;
        for (int k = 0; k < 4; k++) begin
            v.exp0[k] = e0;
            v.exp1[k] = e1;
        end
        return v;
    endfunction

    task automatic checkOutput(input string what, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, actual, expected);
        else
            n_pass++;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_busy"},   32'(bus0.busy),     32'd0);
        checkOutput({tag, "_done"},   32'(bus0.done),     32'd0);
        checkOutput({tag, "_crd"},    32'(bus0.crd),      32'd0);
        checkOutput({tag, "_caddr"},  32'(bus0.caddr_rd), 32'd0);
        checkOutput({tag, "_csel"},   32'(bus0.csel),     32'd0);
        checkOutput({tag, "_waddr"},  32'(bus0.waddr),    32'd0);
        checkOutput({tag, "_oidx"},   32'(bus0.oidx),     32'd0);
        checkOutput({tag, "_ovalid"}, 32'(bus0.ovalid),   32'd0);
        checkOutput({tag, "_odata"},  32'(bus0.odata),    32'd0);
        checkOutput({tag, "_busy1"},  32'(bus1.busy),     32'd0);
        checkOutput({tag, "_odata1"}, 32'(bus1.odata),    32'd0);
    endtask

    task automatic loadModel(input vec_t v);
        cur_x0 = v.x0; cur_xr = v.xr; cur_w0 = v.w0; cur_wr = v.wr;
        cur_bias = v.bias;
    endtask

    task automatic applyStimulus(input vec_t v);
        int t0, n0, n1, exp_addr, rd_count, addr_err, csel_err, busy_err, done_at;
        bit got_done;
        n0 = 0; n1 = 0; exp_addr = 0; rd_count = 0;
        addr_err = 0; csel_err = 0; busy_err = 0; done_at = 0; got_done = 1'b0;
        loadModel(v);
        @(negedge clk);
        bus0.start = 1'b1; bus1.start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus0.start = 1'b0; bus1.start = 1'b0;
        for (int k = 0; k < RUN_BOUND; k++) begin
            if (bus0.crd) begin
                if (int'(bus0.caddr_rd) != exp_addr) addr_err++;
                if (int'(bus0.waddr) != n0 * N_IN + exp_addr) addr_err++;
                exp_addr = (exp_addr == N_IN - 1) ? 0 : exp_addr + 1;
                rd_count++;
            end
            if (bus0.csel != (bus0.crd ? 3'b101 : 3'b000)) csel_err++;
            if (!bus0.busy) busy_err++;
            if (bus0.ovalid) begin
                if (n0 < N_OUT) begin
                    checkOutput("odata", 32'(bus0.odata), 32'(v.exp0[n0]));
                    checkOutput("oidx", 32'(bus0.oidx), 32'(n0));
                    checkOutput("ovalid_cycle", cyc - t0, (N_IN + 2) * (n0 + 1));
                end
                n0++;
            end
            if (bus1.ovalid) begin
                if (n1 < N_OUT)
                    checkOutput("odata_relu", 32'(bus1.odata), 32'(v.exp1[n1]));
                n1++;
            end
            if (bus0.done) begin
                got_done = 1'b1;
                done_at = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        checkOutput("done_seen", 32'(got_done), 32'd1);
        if (got_done) begin
            checkOutput("done_cycle", done_at, DONE_AT);
            @(negedge clk);
            checkOutput("busy_after_done", 32'(bus0.busy), 32'd0);
            checkOutput("done_one_cycle", 32'(bus0.done), 32'd0);
        end
        checkOutput("ovalid_count", n0, N_OUT);
        checkOutput("ovalid_count_relu", n1, N_OUT);
        checkOutput("read_count", rd_count, N_IN * N_OUT);
        checkOutput("addr_errors", addr_err, 0);
        checkOutput("csel_errors", csel_err, 0);
        checkOutput("busy_gaps", busy_err, 0);
    endtask

    // Ignored start at cycle 100, reset at cycle 3000, then a clean rerun of the first vector.
    task automatic runResetSequence();
        int t0, first_ov, n_ov;
        first_ov = -1; n_ov = 0;
        loadModel(vecs[0]);
        @(negedge clk);
        bus0.start = 1'b1; bus1.start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus0.start = 1'b0; bus1.start = 1'b0;
        while (cyc - t0 < 3000) begin
            bus0.start = (cyc - t0 == 100);
            bus1.start = (cyc - t0 == 100);
            if (bus0.ovalid) begin
                n_ov++;
                if (first_ov < 0) first_ov = cyc - t0;
                checkOutput("t6_odata", 32'(bus0.odata), 32'h40000);
            end
            @(negedge clk);
        end
        bus0.start = 1'b0; bus1.start = 1'b0;
        checkOutput("t6_first_ovalid_cycle", first_ov, N_IN + 2);
        checkOutput("t6_ovalid_count", n_ov, 1);
        checkOutput("t6_busy_before_reset", 32'(bus0.busy), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        checkReset("t6");
        reset = 1'b1;
        applyStimulus(vecs[0]);
    endtask

    initial begin
        vecs[0] = mkVec(20'h00080, 20'h00080, 20'h10000, 20'h10000, 20'h40000, 20'h40000);
        vecs[1] = mkVec(20'h10000, 20'h10000, 20'h10000, 20'h10000, 20'h7FFFF, 20'h7FFFF);
        vecs[2] = mkVec(20'h10000, 20'h10000, 20'hF0000, 20'hF0000, 20'h80000, 20'h00000);
        vecs[3] = mkVec(20'h00001, 20'h00000, 20'h08000, 20'h00000, 20'h00001, 20'h00001);
        vecs[4] = mkVec(20'h00001, 20'h00000, 20'h07FFF, 20'h00000, 20'h00000, 20'h00000);
        vecs[5] = mkVec(20'h00000, 20'h00000, 20'h10000, 20'h10000, 20'h00000, 20'h00000);
        vecs[5].bias[0] = 20'h01310; vecs[5].exp0[0] = 20'h01310; vecs[5].exp1[0] = 20'h01310;
        vecs[5].bias[1] = 20'hF7295; vecs[5].exp0[1] = 20'hF7295; vecs[5].exp1[1] = 20'h00000;
        vecs[5].bias[2] = 20'h00000; vecs[5].exp0[2] = 20'h00000; vecs[5].exp1[2] = 20'h00000;
        vecs[5].bias[3] = 20'h7FFFF; vecs[5].exp0[3] = 20'h7FFFF; vecs[5].exp1[3] = 20'h7FFFF;

        bus0.start = 1'b0; bus1.start = 1'b0;
        cur_x0 = '0; cur_xr = '0; cur_w0 = '0; cur_wr = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkReset("rst");
        reset = 1'b1;

        for (int t = 0; t < 6; t++) begin
            $display("[TB] vector %0d", t);
            applyStimulus(vecs[t]);
        end
        $display("[TB] reset sequence");
        runResetSequence();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
